// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory among fetch, data and debug requesters.
// Priority debug > data > fetch; fetch is forced through after STARVE_MAX consecutive losses to data.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_e;
  typedef enum logic [1:0] {SRC_IF, SRC_DM, SRC_DBG} src_e;

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic              we_q, we_d;
  logic [3:0]        lat_q, lat_d;
  logic [7:0]        starve_q, starve_d;
  logic [15:0]       conflict_q, conflict_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic multi_req;
  logic fetch_forced;
  logic grant;

  assign multi_req    = (if_req & dm_req) | (if_req & dbg_req) | (dm_req & dbg_req);
  assign fetch_forced = if_req && (starve_q == STARVE_MAX[7:0]);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    we_d        = we_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    conflict_d  = conflict_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    dbg_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    grant       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (multi_req && (conflict_q != '1)) begin
          conflict_d = conflict_q + 16'd1;
        end
        // Losing to debug leaves the starvation count alone; only data wins count against fetch.
        if (dbg_req) begin
          src_d       = SRC_DBG;
          we_d        = dbg_we;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
        end else if (fetch_forced || (if_req && !dm_req)) begin
          src_d       = SRC_IF;
          we_d        = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end else if (dm_req) begin
          src_d       = SRC_DM;
          we_d        = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req) begin
            starve_d = starve_q + 8'd1;
          end
        end else begin
          grant = 1'b0;
        end
        if (grant) begin
          state_d  = ST_ACCESS;
          mem_en_d = 1'b1;
          mem_we_d = we_d;
        end
      end
      ST_ACCESS: begin
        lat_d   = MEM_LAT[3:0];
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == 4'd1) begin
          state_d = ST_RESP;
          case (src_q)
            SRC_IF: begin
              if_ack_d = 1'b1;
              if (!we_q) if_rdata_d = mem_rdata;
            end
            SRC_DM: begin
              dm_ack_d = 1'b1;
              if (!we_q) dm_rdata_d = mem_rdata;
            end
            default: begin
              dbg_ack_d = 1'b1;
              if (!we_q) dbg_rdata_d = mem_rdata;
            end
          endcase
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_IF;
      we_q        <= 1'b0;
      lat_q       <= '0;
      starve_q    <= '0;
      conflict_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      dbg_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      we_q        <= we_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      conflict_q  <= conflict_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign if_ack       = if_ack_q;
  assign if_rdata     = if_rdata_q;
  assign dm_ack       = dm_ack_q;
  assign dm_rdata     = dm_rdata_q;
  assign dbg_ack      = dbg_ack_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants and acks,
// a negedge monitor compares every memory strobe and ack against it.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;
  localparam int P_IF  = 0;
  localparam int P_DM  = 1;
  localparam int P_DBG = 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  logic  clock = 1'b0;
  logic  reset_n = 1'b1;
  logic  if_req = 1'b0;
  addr_t if_addr = '0;
  logic  if_ack;
  data_t if_rdata;
  logic  dm_req = 1'b0;
  logic  dm_we = 1'b0;
  addr_t dm_addr = '0;
  data_t dm_wdata = '0;
  logic  dm_ack;
  data_t dm_rdata;
  logic  dbg_req = 1'b0;
  logic  dbg_we = 1'b0;
  addr_t dbg_addr = '0;
  data_t dbg_wdata = '0;
  logic  dbg_ack;
  data_t dbg_rdata;
  logic  mem_en;
  logic  mem_we;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;
  logic [15:0] conflict_cnt;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory: data valid MEM_LAT cycles after the strobe, random filler otherwise.
  data_t mem [1<<ADDR_W];
  data_t rd_pipe [MEM_LAT];
  always @(posedge clock) begin
    rd_pipe[0] <= mem_en ? mem[mem_addr] : data_t'($urandom);
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // Reference model: one grant per MEM_LAT+3 cycles, expected acks queued for the monitor.
  typedef struct {
    int    src;
    data_t rdata;
    int    ack_cyc;
  } exp_t;

  exp_t  exp_q[$];
  data_t ref_mem [1<<ADDR_W];
  data_t last_rd [3];
  int    cyc, next_arb, arb_edge, m_starve, exp_conflict, m_src, m_n;
  logic  arb_we;
  addr_t arb_addr;
  data_t arb_wdata;
  exp_t  m_e;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0; next_arb = 1; arb_edge = -100; m_starve = 0; exp_conflict = 0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) last_rd[i] = '0;
    end else begin
      cyc++;
      if (cyc >= next_arb) begin
        m_n = int'(if_req) + int'(dm_req) + int'(dbg_req);
        if (m_n >= 2 && exp_conflict < 65535) exp_conflict++;
        m_src = -1;
        if (dbg_req) m_src = P_DBG;
        else if (if_req && m_starve >= STARVE_MAX) m_src = P_IF;
        else if (dm_req) m_src = P_DM;
        else if (if_req) m_src = P_IF;
        if (m_src == P_DM && if_req) m_starve++;
        if (m_src == P_IF) m_starve = 0;
        if (m_src >= 0) begin
          case (m_src)
            P_IF:    begin arb_we = 1'b0;   arb_addr = if_addr;  arb_wdata = '0;        end
            P_DM:    begin arb_we = dm_we;  arb_addr = dm_addr;  arb_wdata = dm_wdata;  end
            default: begin arb_we = dbg_we; arb_addr = dbg_addr; arb_wdata = dbg_wdata; end
          endcase
          if (arb_we) ref_mem[arb_addr] = arb_wdata;
          else last_rd[m_src] = ref_mem[arb_addr];
          m_e.src = m_src;
          m_e.rdata = last_rd[m_src];
          m_e.ack_cyc = cyc + MEM_LAT + 1;
          exp_q.push_back(m_e);
          arb_edge = cyc;
          next_arb = cyc + MEM_LAT + 3;
        end
      end
    end
  end

  function automatic data_t rdata_of(input int p);
    case (p)
      P_IF:    return if_rdata;
      P_DM:    return dm_rdata;
      default: return dbg_rdata;
    endcase
  endfunction

  function automatic logic ack_of(input int p);
    case (p)
      P_IF:    return if_ack;
      P_DM:    return dm_ack;
      default: return dbg_ack;
    endcase
  endfunction

  int   ack_log[$];
  int   last_men_cyc = -1;
  int   last_ack_cyc = -1;
  int   mon_n, mon_which;
  exp_t mon_e;

  always @(negedge clock) begin
    if (reset_n) begin
      chk("mem_en", 32'(mem_en), 32'(cyc == arb_edge));
      if (mem_en) begin
        last_men_cyc = cyc;
        chk("mem_we", 32'(mem_we), 32'(arb_we));
        chk("mem_addr", 32'(mem_addr), 32'(arb_addr));
        chk("mem_wdata", mem_wdata, arb_wdata);
      end
      chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_conflict));
      mon_n = int'(if_ack) + int'(dm_ack) + int'(dbg_ack);
      if (mon_n > 1) chk("ack_onehot", 32'(mon_n), 32'd1);
      if (mon_n != 0) begin
        mon_which = dbg_ack ? P_DBG : (dm_ack ? P_DM : P_IF);
        last_ack_cyc = cyc;
        ack_log.push_back(mon_which);
        chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("ack_src", 32'(mon_which), 32'(mon_e.src));
          chk("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
          chk("rdata", rdata_of(mon_e.src), mon_e.rdata);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].ack_cyc) begin
        chk("ack_missing", 32'(cyc), 32'(exp_q[0].ack_cyc));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic start(input int p, input logic we, input addr_t a, input data_t d);
    case (p)
      P_IF:    begin if_req = 1'b1; if_addr = a; end
      P_DM:    begin dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d; end
      default: begin dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    endcase
  endtask

  task automatic scramble(input int p);
    start(p, 1'($urandom_range(1)), addr_t'($urandom_range(15)), data_t'($urandom));
  endtask

  task automatic drop(input int p);
    case (p)
      P_IF:    if_req = 1'b0;
      P_DM:    dm_req = 1'b0;
      default: dbg_req = 1'b0;
    endcase
  endtask

  task automatic finish(input int p, input bit jitter);
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (ack_of(p)) break;
      n++;
      if (n > 400) begin
        chk("ack_timeout", 32'(n), 32'd0);
        break;
      end
      if (jitter) scramble(p);
    end
    drop(p);
  endtask

  task automatic check_order(input string name, input int exp_ord[$]);
    chk({name, "_count"}, 32'(ack_log.size()), 32'(exp_ord.size()));
    for (int i = 0; i < exp_ord.size(); i++)
      chk(name, 32'((i < ack_log.size()) ? ack_log[i] : -1), 32'(exp_ord[i]));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_acks"}, 32'({if_ack, dm_ack, dbg_ack}), 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
    chk({tag, "_conflict"}, 32'(conflict_cnt), 32'd0);
  endtask

  task automatic rand_port(input int p, input int n);
    int gap;
    for (int t = 0; t < n; t++) begin
      gap = (p == P_DBG) ? 2 + int'($urandom_range(4)) : int'($urandom_range(3));
      repeat (gap) @(negedge clock);
      scramble(p);
      finish(p, 1'b1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int c;
  data_t v;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      v = data_t'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[5] = 32'h8C22_0004;   ref_mem[5] = 32'h8C22_0004;
    mem[100] = 32'h1357_9BDF; ref_mem[100] = 32'h1357_9BDF;

    #2 reset_n = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);

    // Single fetch: strobe one cycle after the sampling edge, ack MEM_LAT+1 edges later.
    c = cyc;
    start(P_IF, 1'b0, 10'd5, '0);
    finish(P_IF, 1'b0);
    @(negedge clock);
    chk("t1_men_cyc", 32'(last_men_cyc), 32'(c + 1));
    chk("t1_ack_cyc", 32'(last_ack_cyc), 32'(c + 4));
    chk("t1_if_rdata", if_rdata, 32'h8C22_0004);
    chk("t1_conflict", 32'(conflict_cnt), 32'd0);

    // Store then load.
    start(P_DM, 1'b1, 10'd7, 32'hDEAD_BEEF);
    finish(P_DM, 1'b0);
    @(negedge clock);
    chk("t2_store_keeps_rdata", dm_rdata, 32'd0);
    start(P_DM, 1'b0, 10'd7, 32'h0);
    finish(P_DM, 1'b0);
    @(negedge clock);
    chk("t2_load", dm_rdata, 32'hDEAD_BEEF);

    // Fetch and data together.
    ack_log.delete();
    start(P_IF, 1'b0, 10'd5, '0);
    start(P_DM, 1'b0, 10'd7, '0);
    fork
      finish(P_IF, 1'b0);
      finish(P_DM, 1'b0);
    join
    @(negedge clock);
    check_order("t3_order", '{P_DM, P_IF});
    chk("t3_conflict", 32'(conflict_cnt), 32'd1);

    // Starvation guard: data re-requests back to back while fetch waits.
    ack_log.delete();
    start(P_IF, 1'b0, 10'd5, '0);
    start(P_DM, 1'b0, 10'd20, '0);
    fork
      begin
        finish(P_IF, 1'b0);
        start(P_IF, 1'b0, 10'd11, '0);
        finish(P_IF, 1'b0);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          finish(P_DM, 1'b0);
          start(P_DM, 1'b0, addr_t'(21 + k), '0);
        end
        finish(P_DM, 1'b0);
      end
    join
    @(negedge clock);
    check_order("t4_order", '{P_DM, P_DM, P_DM, P_IF, P_DM, P_IF});
    chk("t4_conflict", 32'(conflict_cnt), 32'd6);

    // Debug beats everyone; its write is visible to the later fetch.
    ack_log.delete();
    start(P_DBG, 1'b1, 10'd0, 32'h1);
    start(P_IF, 1'b0, 10'd0, '0);
    start(P_DM, 1'b0, 10'd7, '0);
    fork
      finish(P_DBG, 1'b0);
      finish(P_IF, 1'b0);
      finish(P_DM, 1'b0);
    join
    @(negedge clock);
    check_order("t5_order", '{P_DBG, P_DM, P_IF});
    chk("t5_if_rdata", if_rdata, 32'h1);
    chk("t5_dbg_rdata", dbg_rdata, 32'd0);
    chk("t5_conflict", 32'(conflict_cnt), 32'd8);

    // Random contention with request fields changing while waiting.
    fork
      rand_port(P_IF, 40);
      rand_port(P_DM, 40);
      rand_port(P_DBG, 25);
    join
    repeat (MEM_LAT + 4) @(negedge clock);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a load waits on memory.
    start(P_DM, 1'b0, 10'd7, '0);
    c = 0;
    while (!mem_en && c < 20) begin
      @(negedge clock);
      c++;
    end
    chk("t6_men_seen", 32'(mem_en), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    dm_req = 1'b0;
    #1 chk_zero("t6_async");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    c = cyc;
    start(P_IF, 1'b0, 10'd100, '0);
    finish(P_IF, 1'b0);
    @(negedge clock);
    chk("t6_men_cyc", 32'(last_men_cyc), 32'(c + 1));
    chk("t6_ack_cyc", 32'(last_ack_cyc), 32'(c + 4));
    chk("t6_if_rdata", if_rdata, 32'h1357_9BDF);
    chk("t6_dm_rdata", dm_rdata, 32'd0);
    repeat (MEM_LAT + 4) @(negedge clock);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
